reorder_buf12: RTL and testbench

REORDER_BUF12 -- requirements
Module: reorder_buf12

---
 rtl/reorder_buf12_pkg.sv | 21 ++
 rtl/reorder_buf12_digit_rev_cnt3x2x2.sv | 40 ++++
 rtl/reorder_buf12.sv | 103 ++++++++++
 tb/tb_reorder_buf12.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buf12_pkg.sv
// Shared constants for the 12-point mixed-radix (3x2x2) FFT output reorder stage.
// Holds the frame size, the radix sizes and the arrival-index to bank-address table.
package reorder_buf12_pkg;

    localparam int N      = 12;
    localparam int RADIX0 = 3;
    localparam int RADIX1 = 2;
    localparam int RADIX2 = 2;
    localparam int ADDR_W = 4;

    // Entry m (LSB first) is the bank address k for arrival index m.
    localparam logic [N*ADDR_W-1:0] M2K_TABLE = {
        4'd11, 4'd5, 4'd8, 4'd2, 4'd10, 4'd4,
        4'd7,  4'd1, 4'd9, 4'd3, 4'd6,  4'd0
    };

    function automatic logic [ADDR_W-1:0] m_to_k(input logic [ADDR_W-1:0] m);
        return M2K_TABLE[m*ADDR_W +: ADDR_W];
    endfunction

endpackage

// File: rtl/reorder_buf12_digit_rev_cnt3x2x2.sv
// Mixed-radix arrival counter: digits d0 (radix 3), d1, d2 (radix 2), d2 fastest,
// so {d0,d1,d2} equals the arrival index m; k is the digit-reversed bank address.
module digit_rev_cnt3x2x2
    import reorder_buf12_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] k,
    output logic              last
);

    logic [1:0] d0_reg;
    logic       d1_reg;
    logic       d2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            d0_reg <= 2'd0;
            d1_reg <= 1'b0;
            d2_reg <= 1'b0;
        end else if (en) begin
            if (d2_reg == 1'(RADIX2 - 1)) begin
                d2_reg <= 1'b0;
                if (d1_reg == 1'(RADIX1 - 1)) begin
                    d1_reg <= 1'b0;
                    d0_reg <= (d0_reg == 2'(RADIX0 - 1)) ? 2'd0 : d0_reg + 2'd1;
                end else begin
                    d1_reg <= d1_reg + 1'b1;
                end
            end else begin
                d2_reg <= d2_reg + 1'b1;
            end
        end
    end

    assign k    = m_to_k({d0_reg, d1_reg, d2_reg});
    assign last = ({d0_reg, d1_reg, d2_reg} == ADDR_W'(N - 1));

endmodule

// File: rtl/reorder_buf12.sv
// Ping-pong reorder buffer: writes each 12-point frame in digit-reversed address order
// and reads the completed bank linearly, giving natural frequency order at the output.
module reorder_buf12
    import reorder_buf12_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_last
);

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_last;

    logic              wr_bank_reg;
    logic              rd_bank_reg;
    logic              rd_active_reg;
    logic [ADDR_W-1:0] rd_cnt_reg;
    logic              rd_valid_reg;
    logic              rd_last_reg;
    logic              rd_sel_reg;

    logic [2*WIDTH-1:0] bank_q [2];

    digit_rev_cnt3x2x2 u_wr_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (di_en),
        .k    (wr_addr),
        .last (wr_last)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [2*WIDTH-1:0] mem [N];
            logic [2*WIDTH-1:0] rd_q_reg;

            // Contents are deliberately not reset; only the control path is.
            always_ff @(posedge clk) begin
                if (!rst && di_en && wr_bank_reg == 1'(gi))
                    mem[wr_addr] <= {di_re, di_im};
                if (rd_active_reg && rd_bank_reg == 1'(gi))
                    rd_q_reg <= mem[rd_cnt_reg];
            end

            assign bank_q[gi] = rd_q_reg;
        end
    endgenerate

    // A newly completed frame restarts the read even if one is still running;
    // the final read of the old frame happens on that same edge, so nothing is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            rd_active_reg <= 1'b0;
            rd_cnt_reg    <= '0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            rd_sel_reg    <= 1'b0;
        end else begin
            rd_valid_reg <= rd_active_reg;
            rd_last_reg  <= rd_active_reg && (rd_cnt_reg == ADDR_W'(N - 1));
            rd_sel_reg   <= rd_bank_reg;
            if (di_en && wr_last) begin
                wr_bank_reg   <= ~wr_bank_reg;
                rd_bank_reg   <= wr_bank_reg;
                rd_active_reg <= 1'b1;
                rd_cnt_reg    <= '0;
            end else if (rd_active_reg) begin
                if (rd_cnt_reg == ADDR_W'(N - 1)) begin
                    rd_active_reg <= 1'b0;
                    rd_cnt_reg    <= '0;
                end else begin
                    rd_cnt_reg <= rd_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            do_en   <= 1'b0;
            do_last <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
        end else begin
            do_en   <= rd_valid_reg;
            do_last <= rd_last_reg;
            if (rd_valid_reg)
                {do_re, do_im} <= bank_q[rd_sel_reg];
        end
    end

endmodule

// File: tb/tb_reorder_buf12.sv
// Directed bench for reorder_buf12: ramp, back-to-back, gapped, reset-abort and
// full-scale frames, checked against a hand-derived natural-order table.
module tb_reorder_buf12;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         di_en = 1'b0;
    logic [W-1:0] di_re = '0;
    logic [W-1:0] di_im = '0;
    logic         do_en;
    logic [W-1:0] do_re;
    logic [W-1:0] do_im;
    logic         do_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_last = 0;

    // Arrival index m that lands at output position k (inverse of 0,6,3,9,1,7,4,10,2,8,5,11).
    int exp_m [12] = '{0, 4, 8, 2, 6, 10, 1, 5, 9, 3, 7, 11};

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
        int           cyc;
    } obs_t;
    obs_t obs [$];

    reorder_buf12 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_last (do_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (do_en) begin
            obs.push_back('{re: do_re, im: do_im, last: do_last, cyc: cyc});
            $display("out cyc=%0d re=%0h im=%0h last=%0b", cyc, do_re, do_im, do_last);
        end
        if (do_last && !do_en) bad_last++;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] gen_re(input int mode, input int base, input int m);
        if (mode == 0) return W'(base + m);
        return (m % 2 == 1) ? 14'h2000 : 14'h3FFF;
    endfunction

    function automatic logic [W-1:0] gen_im(input int mode, input int base, input int m);
        if (mode == 0) return W'(-(base + m));
        return (m % 2 == 1) ? 14'h3FFF : 14'h2000;
    endfunction

    // Drives samples m = 0..n_send-1; inserts gap_len idle cycles after m == gap_after.
    task automatic send_frame(input int mode, input int base, input int n_send,
                              input int gap_after, input int gap_len, output int t_last);
        t_last = 0;
        for (int m = 0; m < n_send; m++) begin
            @(negedge clk);
            di_en = 1'b1;
            di_re = gen_re(mode, base, m);
            di_im = gen_im(mode, base, m);
            t_last = cyc + 1;
            if (m == gap_after) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    di_en = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        di_en = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int mode, input int base,
                               input int t_last, input int idx);
        for (int k = 0; k < 12; k++) begin
            if (idx + k >= obs.size()) begin
                chk({tag, "_missing"}, 32'(obs.size()), 32'(idx + k + 1));
                return;
            end
            chk($sformatf("%s_re%0d", tag, k), 32'(obs[idx+k].re), 32'(gen_re(mode, base, exp_m[k])));
            chk($sformatf("%s_im%0d", tag, k), 32'(obs[idx+k].im), 32'(gen_im(mode, base, exp_m[k])));
            chk($sformatf("%s_last%0d", tag, k), 32'(obs[idx+k].last), 32'(k == 11));
            chk($sformatf("%s_cyc%0d", tag, k), 32'(obs[idx+k].cyc), 32'(t_last + 2 + k));
        end
    endtask

    initial begin
        int t0, t1, t2, t_first;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_do_en", 32'(do_en), 32'd0);
        chk("rst_do_last", 32'(do_last), 32'd0);
        chk("rst_do_re", 32'(do_re), 32'd0);
        chk("rst_do_im", 32'(do_im), 32'd0);
        rst = 1'b0;

        // Single gapless ramp frame; first input edge is t0-11, first output t0+2 (13 cycles).
        send_frame(0, 0, 12, -1, 0, t0);
        t_first = t0 - 11;
        idle(20);
        chk("s1_count", 32'(obs.size()), 32'd12);
        check_frame("s1", 0, 0, t0, 0);
        if (obs.size() > 0) chk("s1_latency", 32'(obs[0].cyc - t_first), 32'd13);
        obs.delete();

        // Three back-to-back frames: 36 contiguous outputs.
        send_frame(0, 0, 12, -1, 0, t0);
        send_frame(0, 100, 12, -1, 0, t1);
        send_frame(0, 200, 12, -1, 0, t2);
        idle(20);
        chk("s2_count", 32'(obs.size()), 32'd36);
        chk("s2_t1", 32'(t1 - t0), 32'd12);
        chk("s2_t2", 32'(t2 - t1), 32'd12);
        check_frame("s2f0", 0, 0, t0, 0);
        check_frame("s2f1", 0, 100, t1, 12);
        check_frame("s2f2", 0, 200, t2, 24);
        obs.delete();

        // 3-cycle input gap after m = 5.
        send_frame(0, 0, 12, 5, 3, t0);
        idle(20);
        chk("s3_count", 32'(obs.size()), 32'd12);
        check_frame("s3", 0, 0, t0, 0);
        obs.delete();

        // Reset after m = 7, then a fresh frame.
        send_frame(0, 50, 8, -1, 0, t0);
        @(negedge clk);
        di_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        chk("s4_abort_count", 32'(obs.size()), 32'd0);
        send_frame(0, 0, 12, -1, 0, t0);
        idle(20);
        chk("s4_count", 32'(obs.size()), 32'd12);
        check_frame("s4", 0, 0, t0, 0);
        obs.delete();

        // Reset during output at k = 4 (visible after edge t0+6).
        send_frame(0, 0, 12, -1, 0, t0);
        @(negedge clk);
        di_en = 1'b0;
        for (int i = 0; i < 40 && cyc < t0 + 6; i++) @(negedge clk);
        chk("s5_sync", 32'(cyc), 32'(t0 + 6));
        chk("s5_k4_en", 32'(do_en), 32'd1);
        chk("s5_k4_re", 32'(do_re), 32'(gen_re(0, 0, exp_m[4])));
        rst = 1'b1;
        @(negedge clk);
        chk("s5_do_en", 32'(do_en), 32'd0);
        chk("s5_do_last", 32'(do_last), 32'd0);
        chk("s5_do_re", 32'(do_re), 32'd0);
        chk("s5_do_im", 32'(do_im), 32'd0);
        rst = 1'b0;
        idle(20);
        chk("s5_count", 32'(obs.size()), 32'd5);
        obs.delete();

        // Full-scale pass-through.
        send_frame(1, 0, 12, -1, 0, t0);
        idle(20);
        chk("s6_count", 32'(obs.size()), 32'd12);
        check_frame("s6", 1, 0, t0, 0);
        obs.delete();

        chk("last_without_en", 32'(bad_last), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
